// File: rtl/memory_dump_tx_pkg.sv
// Shared UART definitions for the memory dump transmitter and the future receiver:
// FSM state encodings and the default bit period.
package memory_dump_tx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

endpackage

// File: rtl/memory_dump_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// Holding clear keeps the count at zero so every FSM state starts a fresh period.
module baud_counter
    import memory_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/memory_dump_tx.sv
// Walks the byte memory from address 0 and sends each byte as a UART 8N1 frame on tx.
// Each byte costs one FETCH cycle plus ten bit periods.
module memory_dump_tx
    import memory_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_BYTES    = 4,
    parameter int ADDR_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

    state_e                 state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [2:0]             bit_cnt_q;
    logic [ADDR_W-1:0]      idx_q;
    logic [ADDR_W-1:0]      idx_d;
    logic                   tx_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   baud_clear;
    logic                   tick;

    assign idx_d      = idx_q + ADDR_W'(1);
    // FETCH is a single cycle, so the bit timer is parked there and runs fresh from START.
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    // NOTE: reset is synchronous, so it is only a priority branch inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A start landing on the done cycle belongs to the finished dump.
                    if (start && !done_q) begin
                        state_q <= ST_FETCH;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    shift_q <= rd_data;
                    tx_q    <= 1'b0;
                    state_q <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_d;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_addr = idx_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_memory_dump_tx.sv
// Self-checking bench for memory_dump_tx: an independent UART line decoder recovers the
// bytes from tx and is compared with the memory image, plus directed timing corner cases.
module tb_memory_dump_tx;

    localparam int CPB       = 4;
    localparam int NBYTES    = 4;
    localparam int DUMP_CYCS = NBYTES * (1 + 10 * CPB);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] mem [NBYTES];
    assign rd_data = mem[rd_addr];

    memory_dump_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (NBYTES),
        .ADDR_W      (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Line monitor: finds each falling edge on an idle line and samples mid-bit.
    logic [7:0] rx_q [$];
    logic [7:0] rx_shift = '0;
    bit         in_frame = 1'b0;
    int         fcnt     = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         frame_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame <= 1'b0;
            fcnt     <= 0;
        end else begin
            if (busy) busy_cnt <= busy_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (!in_frame) begin
                if (tx == 1'b0) begin
                    in_frame <= 1'b1;
                    fcnt     <= 1;
                end
            end else begin
                if (fcnt % CPB == CPB / 2) begin
                    if (fcnt / CPB == 0 && tx != 1'b0) frame_err <= frame_err + 1;
                    if (fcnt / CPB >= 1 && fcnt / CPB <= 8) rx_shift[fcnt / CPB - 1] <= tx;
                    if (fcnt / CPB == 9) begin
                        if (tx != 1'b1) frame_err <= frame_err + 1;
                        rx_q.push_back(rx_shift);
                        in_frame <= 1'b0;
                    end
                end
                fcnt <= fcnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [NBYTES-1:0][7:0] m);
        for (int i = 0; i < NBYTES; i++) mem[i] = m[i];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_frames(input string tag, input int base, input logic [NBYTES-1:0][7:0] m);
        check({tag, "_frame_count"}, 32'(rx_q.size() - base), 32'(NBYTES));
        for (int i = 0; i < NBYTES; i++) begin
            if (base + i < rx_q.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[base + i]), 32'(m[i]));
        end
    endtask

    task automatic run_dump(input string tag, input logic [NBYTES-1:0][7:0] m);
        int rb = rx_q.size();
        int bb = busy_cnt;
        int db = done_cnt;
        load(m);
        pulse_start();
        wait_done(tag, 3 * DUMP_CYCS);
        tick();
        tick();
        check({tag, "_busy_cycles"}, 32'(busy_cnt - bb), 32'(DUMP_CYCS));
        check({tag, "_done_pulses"}, 32'(done_cnt - db), 32'd1);
        check({tag, "_rd_addr_hold"}, 32'(rd_addr), 32'(NBYTES - 1));
        check_frames(tag, rb, m);
    endtask

    typedef struct {
        string                   name;
        logic [NBYTES-1:0][7:0]  mem_img;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [NBYTES-1:0][7:0] base_img;
        logic [NBYTES-1:0][7:0] img;
        int rb, bb, db;
        bit hit;

        base_img = {8'h00, 8'hFF, 8'h3C, 8'hA5};
        vecs[0] = '{"t1_ref",   base_img};
        vecs[1] = '{"t1_zero",  {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{"t1_ones",  {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[3] = '{"t1_mixed", {8'hAA, 8'h55, 8'h80, 8'h01}};
        load(base_img);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        tick();

        // Start latency and start-bit width (byte 0 = A5, LSB 1 ends the start bit visibly)
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_busy_n1", 32'(busy), 32'd1);
        check("lat_tx_n1", 32'(tx), 32'd1);
        check("lat_rd_addr_fetch", 32'(rd_addr), 32'd0);
        tick();
        check("lat_tx_fall_n2", 32'(tx), 32'd0);
        for (int k = 1; k < CPB; k++) begin
            tick();
            check($sformatf("start_bit_low_%0d", k), 32'(tx), 32'd0);
        end
        tick();
        check("start_bit_end", 32'(tx), 32'd1);
        wait_done("t2", 3 * DUMP_CYCS);
        tick();

        // Table of memory images
        for (int v = 0; v < 4; v++) begin
            run_dump(vecs[v].name, vecs[v].mem_img);
            repeat (3) tick();
        end

        // Randomized images with random idle gaps
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NBYTES; i++) img[i] = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 20)) tick();
            run_dump($sformatf("rand%0d", r), img);
        end

        // Extra start pulses at cycles 10 and 100 of a dump are dropped
        load(base_img);
        rb = rx_q.size(); bb = busy_cnt; db = done_cnt;
        pulse_start();
        hit = 1'b0;
        for (int c = 1; c <= 3 * DUMP_CYCS && !hit; c++) begin
            start = (c == 10 || c == 100);
            tick();
            if (done) hit = 1'b1;
        end
        start = 1'b0;
        check("t3_done_seen", 32'(hit), 32'd1);
        repeat (200) tick();
        check("t3_busy_cycles", 32'(busy_cnt - bb), 32'(DUMP_CYCS));
        check("t3_done_pulses", 32'(done_cnt - db), 32'd1);
        check_frames("t3", rb, base_img);

        // Byte 1 rewritten after its FETCH: in-flight frame keeps the old value
        load(base_img);
        rb = rx_q.size();
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 3 * DUMP_CYCS && !hit; c++) begin
            tick();
            if (rd_addr == 2'd1) hit = 1'b1;
        end
        check("t4_reached_byte1", 32'(hit), 32'd1);
        repeat (10) tick();
        mem[1] = 8'h77;
        wait_done("t4a", 3 * DUMP_CYCS);
        tick();
        tick();
        check_frames("t4a", rb, base_img);
        img = base_img;
        img[1] = 8'h77;
        run_dump("t4b", img);

        // Reset during byte 2 DATA aborts the dump
        load(base_img);
        rb = rx_q.size(); db = done_cnt;
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 3 * DUMP_CYCS && !hit; c++) begin
            tick();
            if (rd_addr == 2'd2) hit = 1'b1;
        end
        check("t5_reached_byte2", 32'(hit), 32'd1);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_tx_after_rst", 32'(tx), 32'd1);
        check("t5_busy_after_rst", 32'(busy), 32'd0);
        check("t5_done_after_rst", 32'(done), 32'd0);
        check("t5_rd_addr_after_rst", 32'(rd_addr), 32'd0);
        repeat (200) tick();
        check("t5_no_done", 32'(done_cnt - db), 32'd0);
        check("t5_partial_frames", 32'(rx_q.size() - rb), 32'd2);
        run_dump("t5_after", base_img);

        // Start on the done cycle is ignored; start one cycle later is accepted
        load(base_img);
        pulse_start();
        wait_done("t6a", 3 * DUMP_CYCS);
        start = 1'b1;
        tick();
        check("t6_start_on_done_ignored", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        check("t6_second_start_busy", 32'(busy), 32'd1);
        check("t6_fetch_rd_addr", 32'(rd_addr), 32'd0);
        rb = rx_q.size(); db = done_cnt;
        wait_done("t6b", 3 * DUMP_CYCS);
        tick();
        tick();
        check("t6_done_pulses", 32'(done_cnt - db), 32'd1);
        check_frames("t6", rb, base_img);

        check("framing_errors", 32'(frame_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
